// File: rtl/hilo_mul_controller.sv
// hilo_mul_controller: iterative 32x32 multiply sequencer that owns the HI/LO registers
module hilo_mul_controller #(
    parameter int BPC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Op,
    input  logic        OpValid,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] Result,
    output logic        ResultValid,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int N  = 32 / BPC;
    localparam int CW = $clog2(N) + 1;
    localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_MADD = 4'd3, OP_MADDU = 4'd4,
                           OP_MSUB = 4'd5, OP_MSUBU = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8,
                           OP_MFHI = 4'd9, OP_MFLO = 4'd10, OP_MUL = 4'd11;
    typedef enum logic [1:0] {IDLE, CALC, FIX, ACC} state_t;
    state_t        state;
    logic [3:0]    op_q;
    logic          neg;
    logic [63:0]   mcand;
    logic [31:0]   mplier;
    logic [CW-1:0] cnt;
    logic [63:0]   p;
    logic [63:0]   prod;
    logic          is_nop, is_mul, is_signed, accept, mf_hi, mf_lo, mul_rv;
    logic [31:0]   a_abs, b_abs;
    logic [63:0]   pp, acc_next;
    assign is_nop    = (Op == 4'd0) || (Op >= 4'd12);
    assign is_mul    = (Op >= OP_MULT && Op <= OP_MSUBU) || Op == OP_MUL;
    assign is_signed = Op == OP_MULT || Op == OP_MADD || Op == OP_MSUB || Op == OP_MUL;
    assign Stall     = OpValid && !is_nop && Busy;
    assign accept    = OpValid && !Stall && !Flush && state == IDLE;
    assign mf_hi     = accept && Op == OP_MFHI;
    assign mf_lo     = accept && Op == OP_MFLO;
    assign mul_rv    = state == ACC && op_q == OP_MUL && !Flush;
    // 0x80000000 negates to itself, which is exactly its unsigned magnitude
    assign a_abs     = A[31] ? -A : A;
    assign b_abs     = B[31] ? -B : B;
    assign pp        = mcand * 64'(mplier[BPC-1:0]);
    always_comb begin
        ResultValid = mf_hi || mf_lo || mul_rv;
        Result      = mf_hi ? HI : mf_lo ? LO : mul_rv ? prod[31:0] : 32'd0;
        acc_next    = (op_q == OP_MADD || op_q == OP_MADDU) ? {HI, LO} + prod :
                      (op_q == OP_MSUB || op_q == OP_MSUBU) ? {HI, LO} - prod : prod;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            Busy   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            p      <= '0;
            prod   <= '0;
        end else if (Flush && state != IDLE) begin
            state <= IDLE;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (Op == OP_MTHI) HI <= A;
                    if (Op == OP_MTLO) LO <= A;
                    if (is_mul) begin
                        op_q   <= Op;
                        mcand  <= {32'd0, is_signed ? a_abs : A};
                        mplier <= is_signed ? b_abs : B;
                        neg    <= is_signed && (A[31] ^ B[31]);
                        p      <= '0;
                        cnt    <= CW'(N - 1);
                        state  <= CALC;
                        Busy   <= 1'b1;
                    end
                end
                CALC: begin
                    p      <= p + pp;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    prod  <= neg ? -p : p;
                    state <= ACC;
                end
                default: begin
                    if (op_q != OP_MUL) {HI, LO} <= acc_next;
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
